alu_dispatch: RTL
=================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_i  input  1  reset, asynchronous, active-high.
REQ-003 in_valid_i  input  1  upstream instruction/operands valid.
REQ-004 in_ready_o  output  1  block can accept; driven from a register only.
REQ-005 inst_i  input  32  RV32 instruction word.
REQ-006 rs1_data_i, rs2_data_i  input  32 each  register-file read data.
REQ-007 flush_i  input  1  discard all buffered entries.
REQ-008 out_valid_o  output  1  decoded ALU command valid.
REQ-009 out_ready_i  input  1  ALU/EX stage accepts command.
REQ-010 ctl_o  output  3  ALU op: 0 and, 1 xor, 2 sll, 3 add, 4 sub, 5 mul, 6 sra.
REQ-011 op1_o, op2_o  output  32 each  ALU operands.
REQ-012 rd_o  output  5  destination register, inst[11:7].
REQ-013 reg_write_o, mem_read_o, mem_write_o, branch_o  output  1 each  EX/MEM control.
REQ-014 illegal_o  output  1  decoded instruction unsupported.

Function
REQ-015 Transfer occurs on a cycle where valid and ready are both high; each side's handshake is independent.
REQ-016 Decode is combinational on inst_i; the result is captured into a 2-entry skid buffer (main + skid).
REQ-017 R-type (opcode 0110011), by funct7/funct3: 0000000/111 and; 0000000/100 xor; 0000000/001 sll; 0000000/000 add; 0100000/000 sub; 0000001/000 mul; op1=rs1, op2=rs2, reg_write=1.
REQ-018 addi (0010011/000): ctl add, op2 = sign-extended inst[31:20], reg_write=1.
REQ-019 srai (0010011/101, funct7 0100000): ctl sra, op2 = zero-extended inst[24:20], reg_write=1.
REQ-020 lw (0000011/010): ctl add, op2 = sign-ext I-imm, reg_write=1, mem_read=1.
REQ-021 sw (0100011/010): ctl add, op2 = sign-ext {inst[31:25],inst[11:7]}, mem_write=1.
REQ-022 beq (1100011/000): ctl sub, op1=rs1, op2=rs2, branch=1.
REQ-023 Any other encoding: illegal=1, ctl add, op1=op2=0, all write/mem/branch flags 0; still passed downstream in order.
REQ-024 Latency: accepted instruction appears at outputs the following cycle, earliest.
REQ-025 State: EMPTY (0 entries), ONE (main valid), FULL (main+skid valid); in_ready_o = state != FULL.
REQ-026 EMPTY: accept -> ONE. ONE: accept and no drain -> FULL; drain and no accept -> EMPTY; both -> ONE with new entry. FULL: drain -> ONE, skid moves to main.
REQ-027 Outputs always present the oldest entry; order strictly FIFO.
REQ-028 While out_valid_o=1 and out_ready_i=0, all command outputs hold stable.
REQ-029 flush_i: next state EMPTY regardless of simultaneous accept/drain; input accepted that cycle is discarded.
REQ-030 out_valid_o never depends combinationally on out_ready_i; in_ready_o never on in_valid_i.

Reset
REQ-031 rst_i asserted: state EMPTY, out_valid_o=0, in_ready_o=1, all command outputs and flags 0, immediately (asynchronous), including mid-transfer.
REQ-032 First accept possible on the first rising edge after rst_i deasserts.

Structure
REQ-033 Shared package holds ALU ctl constants (AND..SRA), opcode/funct constants, and the decoded-command struct/bit-layout used by ALU and this block.
REQ-034 One sub-module: alu_decode (purely combinational inst -> command); buffer/FSM lives in alu_dispatch.

Verification
REQ-035 Reset then add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle ctl=3, op1=5, op2=7, rd=3, reg_write=1.
REQ-036 addi with imm 0xFFF, rs1=10 -> ctl=3, op2=0xFFFFFFFF; srai shamt 4 -> ctl=6, op2=4.
REQ-037 out_ready=0, issue 3 back-to-back -> 2 accepted, in_ready=0 third cycle; release -> outputs in issue order, no loss/duplication.
REQ-038 sw imm -4 -> ctl=3, op2=0xFFFFFFFC, mem_write=1, reg_write=0; inst 0xFFFFFFFF -> illegal=1, reg_write=0.
REQ-039 FULL plus flush_i with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input absent.
REQ-040 rst_i pulsed mid-cycle while FULL -> out_valid drops before next edge; random valid/ready soak matches reference-model scoreboard.

Source files
------------

// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU dispatch path.
// Holds the ALU control encodings, the RV32 opcode/funct fields recognised
// by the decoder, the decoded-command struct shared with the ALU, and the
// dispatch buffer state encodings.
package alu_dispatch_pkg;

  // ALU control encodings
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_XOR = 3'd1;
  localparam logic [2:0] ALU_SLL = 3'd2;
  localparam logic [2:0] ALU_ADD = 3'd3;
  localparam logic [2:0] ALU_SUB = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;
  localparam logic [2:0] ALU_SRA = 3'd6;

  // Opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // funct3 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LSW = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;

  // Decoded command, MSB first: ctl, op1, op2, rd, flags
  typedef struct packed {
    logic [2:0]  ctl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;
  } alu_cmd_t;

  // Dispatch buffer occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_dispatch_decode.sv
// Purely combinational RV32 decoder: instruction word + register operands
// to an ALU command.
// Ports: inst (instruction word), rs1_data/rs2_data (register read data),
//        cmd (decoded command).
module alu_decode
  import alu_dispatch_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_cmd_t    cmd
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  // Register index field is resolved by the register file upstream.
  logic       unused_rs1_idx;

  assign opcode         = inst[6:0];
  assign funct3         = inst[14:12];
  assign funct7         = inst[31:25];
  assign unused_rs1_idx = ^inst[19:15];

  always_comb begin
    cmd     = '0;
    cmd.ctl = ALU_ADD;
    cmd.rd  = inst[11:7];
    case (opcode)
      OPC_OP: begin
        cmd.op1       = rs1_data;
        cmd.op2       = rs2_data;
        cmd.reg_write = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_AND}: cmd.ctl = ALU_AND;
          {F7_BASE, F3_XOR}: cmd.ctl = ALU_XOR;
          {F7_BASE, F3_SLL}: cmd.ctl = ALU_SLL;
          {F7_BASE, F3_ADD}: cmd.ctl = ALU_ADD;
          {F7_ALT,  F3_ADD}: cmd.ctl = ALU_SUB;
          {F7_MUL,  F3_ADD}: cmd.ctl = ALU_MUL;
          default:           cmd.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        cmd.op1       = rs1_data;
        cmd.reg_write = 1'b1;
        if (funct3 == F3_ADD) begin
          cmd.op2 = sext12(inst[31:20]);
        end else if (funct3 == F3_SR && funct7 == F7_ALT) begin
          cmd.ctl = ALU_SRA;
          cmd.op2 = {27'd0, inst[24:20]};
        end else begin
          cmd.illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        cmd.op1       = rs1_data;
        cmd.op2       = sext12(inst[31:20]);
        cmd.reg_write = 1'b1;
        cmd.mem_read  = 1'b1;
        cmd.illegal   = (funct3 != F3_LSW);
      end
      OPC_STORE: begin
        cmd.op1       = rs1_data;
        cmd.op2       = sext12({inst[31:25], inst[11:7]});
        cmd.mem_write = 1'b1;
        cmd.illegal   = (funct3 != F3_LSW);
      end
      OPC_BRANCH: begin
        cmd.ctl     = ALU_SUB;
        cmd.op1     = rs1_data;
        cmd.op2     = rs2_data;
        cmd.branch  = 1'b1;
        cmd.illegal = (funct3 != F3_BEQ);
      end
      default: cmd.illegal = 1'b1;
    endcase
    // Unsupported encodings still travel downstream, but as an inert add.
    if (cmd.illegal) begin
      cmd         = '0;
      cmd.ctl     = ALU_ADD;
      cmd.rd      = inst[11:7];
      cmd.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// Decode-and-dispatch stage: decodes an RV32 instruction and holds the
// resulting ALU command in a 2-entry skid buffer (main + skid) in front of
// the EX stage.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready_o and out_valid_o come straight from flops, so neither
// depends combinationally on the other side's valid/ready.
// Ports: clk_i/rst_i (async active-high reset), in_valid_i/in_ready_o/inst_i/
//        rs1_data_i/rs2_data_i (upstream), flush_i (drop buffered entries),
//        out_valid_o/out_ready_i and command outputs (downstream),
//        state_o (buffer state for debug).
module alu_dispatch
  import alu_dispatch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [2:0]  ctl_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic        illegal_o,
  output logic [1:0]  state_o
);

  alu_cmd_t   dec_cmd;
  alu_cmd_t   main_q;
  alu_cmd_t   skid_q;
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       accept;
  logic       drain;

  alu_decode u_decode (
    .inst     (inst_i),
    .rs1_data (rs1_data_i),
    .rs2_data (rs2_data_i),
    .cmd      (dec_cmd)
  );

  assign accept = in_valid_i & in_ready_q;
  assign drain  = out_valid_q & out_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !drain)      state_d = ST_FULL;
        else if (drain && !accept) state_d = ST_EMPTY;
      end
      ST_FULL:  if (drain) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      // Ready/valid are registered copies of the next occupancy.
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      if (!flush_i) begin
        case (state_q)
          ST_EMPTY: if (accept) main_q <= dec_cmd;
          ST_ONE: begin
            if (accept && drain) main_q <= dec_cmd;
            else if (accept)     skid_q <= dec_cmd;
          end
          ST_FULL:  if (drain) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign ctl_o       = main_q.ctl;
  assign op1_o       = main_q.op1;
  assign op2_o       = main_q.op2;
  assign rd_o        = main_q.rd;
  assign reg_write_o = main_q.reg_write;
  assign mem_read_o  = main_q.mem_read;
  assign mem_write_o = main_q.mem_write;
  assign branch_o    = main_q.branch;
  assign illegal_o   = main_q.illegal;
  assign state_o     = state_q;

endmodule
